// File: rtl/axi4lite_mem_responder.sv
// AXI4-Lite slave RAM answering the picorv32 mem_axi_* master; one transaction in flight, writes win.
// Optional randomised ready/response stalls are built in when AXI_MEM_STALL_EN is defined.
module axi4lite_mem_responder #(
   parameter int          MEM_WORDS  = 1024,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata
);
   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {IDLE, B_WAIT, B_RESP, R_WAIT, R_RESP} state_t;

   state_t          state_q, state_d;
   logic            aw_got_q, aw_got_d;
   logic            w_got_q, w_got_d;
   logic [AW-1:0]   aw_idx_q, aw_idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic            bvalid_q, bvalid_d;
   logic            rvalid_q, rvalid_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [31:0]     mem [MEM_WORDS];

   logic            stall, delay;
   logic            in_idle, aw_hs, w_hs, ar_hs, commit;
   logic [AW-1:0]   aw_idx_in, ar_idx, wr_idx;
   logic [31:0]     wr_data;
   logic [3:0]      wr_strb;

`ifdef AXI_MEM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;
   // Fibonacci taps 16,14,13,11
   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   always_ff @(posedge clk) begin
      if (!resetn) lfsr_q <= STALL_SEED;
      else         lfsr_q <= lfsr_d;
   end
   assign stall = lfsr_q[0];
   assign delay = lfsr_q[1];
`else
   assign stall = 1'b0;
   assign delay = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{STALL_SEED, mem_axi_awaddr[31:AW+2], mem_axi_awaddr[1:0],
                        mem_axi_araddr[31:AW+2], mem_axi_araddr[1:0],
                        mem_axi_awprot, mem_axi_arprot};

   assign aw_idx_in = mem_axi_awaddr[AW+1:2];
   assign ar_idx    = mem_axi_araddr[AW+1:2];

   // Readies are held low while reset is asserted so nothing is accepted mid-reset.
   assign in_idle         = resetn && (state_q == IDLE);
   assign mem_axi_awready = in_idle && !aw_got_q && !stall;
   assign mem_axi_wready  = in_idle && !w_got_q && !stall;
   assign mem_axi_arready = in_idle && !stall && !aw_got_q && !w_got_q
                            && !mem_axi_awvalid && !mem_axi_wvalid;

   assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
   assign w_hs   = mem_axi_wvalid && mem_axi_wready;
   assign ar_hs  = mem_axi_arvalid && mem_axi_arready;
   assign commit = in_idle && (aw_got_q || aw_hs) && (w_got_q || w_hs);

   assign wr_idx  = aw_got_q ? aw_idx_q : aw_idx_in;
   assign wr_data = w_got_q ? wdata_q : mem_axi_wdata;
   assign wr_strb = w_got_q ? wstrb_q : mem_axi_wstrb;

   always_comb begin
      state_d  = state_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      aw_idx_d = aw_idx_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bvalid_d = bvalid_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               aw_idx_d = aw_idx_in;
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = mem_axi_wdata;
               wstrb_d = mem_axi_wstrb;
            end
            if (commit) begin
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               state_d  = delay ? B_WAIT : B_RESP;
               bvalid_d = !delay;
            end else if (ar_hs) begin
               rdata_d  = mem[ar_idx];
               state_d  = delay ? R_WAIT : R_RESP;
               rvalid_d = !delay;
            end
         end
         B_WAIT: if (!delay) begin
            state_d  = B_RESP;
            bvalid_d = 1'b1;
         end
         B_RESP: if (mem_axi_bready) begin
            state_d  = IDLE;
            bvalid_d = 1'b0;
         end
         R_WAIT: if (!delay) begin
            state_d  = R_RESP;
            rvalid_d = 1'b1;
         end
         R_RESP: if (mem_axi_rready) begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         aw_idx_q <= aw_idx_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         bvalid_q <= bvalid_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   // RAM has no reset; contents survive resetn.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++)
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   assign mem_axi_bvalid = bvalid_q;
   assign mem_axi_rvalid = rvalid_q;
   assign mem_axi_rdata  = rdata_q;
endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// Scoreboard bench for axi4lite_mem_responder: reference RAM model, read data queued on AR issue.
module tb_axi4lite_mem_responder;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
   logic [3:0]  wstrb = '0;

   logic [31:0] model [1024];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   axi4lite_mem_responder #(.MEM_WORDS(1024), .STALL_SEED(16'hACE1)) dut (
      .clk(clk), .resetn(resetn),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
      .mem_axi_awprot(3'b000),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
      .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
      .mem_axi_arprot(3'b000),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_wr(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb);
      logic [9:0] idx = addr[11:2];
      for (int i = 0; i < 4; i++)
         if (strb[i]) model[idx][8*i +: 8] = data[8*i +: 8];
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_awready"}, {31'b0, awready}, 0);
      chk({tag, "_wready"},  {31'b0, wready},  0);
      chk({tag, "_arready"}, {31'b0, arready}, 0);
      chk({tag, "_bvalid"},  {31'b0, bvalid},  0);
      chk({tag, "_rvalid"},  {31'b0, rvalid},  0);
      chk({tag, "_rdata"},   rdata,            0);
   endtask

   // AW offered from cycle aw_at, W from cycle w_at; bvalid must follow the last handshake by one cycle.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_at, input int w_at);
      bit aw_done = 0, w_done = 0;
      int c = 0;
      while (!(aw_done && w_done) && c < 50) begin
         @(negedge clk);
         awvalid = !aw_done && c >= aw_at; awaddr = addr;
         wvalid  = !w_done && c >= w_at;   wdata = data; wstrb = strb;
         #1;
         if (aw_at == 0 && w_at == 0 && c == 0)
            chk("same_cycle_readies", {30'b0, awready, wready}, 32'h3);
         if (!aw_done && (c < aw_at || w_done))
            chk("no_early_bvalid", {31'b0, bvalid}, 0);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready)   w_done  = 1;
         c++;
      end
      if (!(aw_done && w_done)) chk("write_accept_timeout", 0, 1);
      model_wr(addr, data, strb);
      @(negedge clk);
      awvalid = 0; wvalid = 0; bready = 1;
      #1;
      chk("bvalid_latency", {31'b0, bvalid}, 1);
      @(negedge clk);
      bready = 0;
      #1;
      chk("bvalid_drop", {31'b0, bvalid}, 0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int hold);
      int c = 0;
      exp_q.push_back(model[addr[11:2]]);
      @(negedge clk);
      arvalid = 1; araddr = addr;
      #1;
      while (!arready && c < 50) begin
         @(negedge clk); #1; c++;
      end
      if (!arready) chk("ar_accept_timeout", 0, 1);
      @(negedge clk);
      arvalid = 0;
      #1;
      chk("rvalid_latency", {31'b0, rvalid}, 1);
      for (int i = 0; i < hold; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         chk("rvalid_held", {31'b0, rvalid}, 1);
         chk("rdata_stable", rdata, exp_q[0]);
      end
      if (hold > 0) @(negedge clk);
      rready = 1;
      #1;
      if (exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
      @(negedge clk);
      rready = 0;
      #1;
      chk("rvalid_drop", {31'b0, rvalid}, 0);
   endtask

   initial begin
      // Reset state, observed while resetn is still low
      repeat (2) @(negedge clk);
      #1;
      chk_idle_outputs("reset");
      @(negedge clk);
      resetn = 1;

      axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      axi_read(32'h10, 0);

      // W first, AW three cycles later, half the byte lanes
      axi_write(32'h20, 32'hAABBCCDD, 4'hF, 0, 0);
      axi_write(32'h20, 32'h11223344, 4'b0101, 3, 0);
      chk("strb_model", model[8], 32'hAA22CC44);
      axi_read(32'h20, 0);

      // Backpressure on R for 5 cycles
      axi_read(32'h10, 5);

      // All three requests together: write must win, AR waits for the B handshake
      @(negedge clk);
      awvalid = 1; awaddr = 32'h40; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      arvalid = 1; araddr = 32'h40;
      #1;
      chk("prio_arready_idle", {31'b0, arready}, 0);
      chk("prio_aw_w_ready", {30'b0, awready, wready}, 32'h3);
      model_wr(32'h40, 32'hCAFEF00D, 4'hF);
      exp_q.push_back(model[16]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         awvalid = 0; wvalid = 0;
         bready = (i == 2);
         #1;
         chk("prio_bvalid", {31'b0, bvalid}, 1);
         chk("prio_arready_b", {31'b0, arready}, 0);
      end
      @(negedge clk);
      bready = 0;
      #1;
      chk("prio_bvalid_drop", {31'b0, bvalid}, 0);
      chk("prio_arready_after", {31'b0, arready}, 1);
      @(negedge clk);
      arvalid = 0; rready = 1;
      #1;
      chk("prio_rvalid", {31'b0, rvalid}, 1);
      if (exp_q.size() > 0) chk("prio_rdata", rdata, exp_q.pop_front());
      @(negedge clk);
      rready = 0;
      #1;
      chk("prio_rvalid_drop", {31'b0, rvalid}, 0);

      // Address wrap modulo MEM_WORDS*4
      axi_write(32'h1000, 32'h1234, 4'hF, 0, 0);
      axi_read(32'h0, 0);
      chk("wrap_model", model[0], 32'h1234);

      // Reset between AW and W: partial write dropped
      axi_write(32'h80, 32'h55AA55AA, 4'hF, 0, 0);
      axi_write(32'h84, 32'h0BADF00D, 4'hF, 0, 0);
      @(negedge clk);
      awvalid = 1; awaddr = 32'h80;
      #1;
      chk("rst_aw_accept", {31'b0, awready}, 1);
      @(negedge clk);
      awvalid = 0; resetn = 0;
      @(negedge clk);
      #1;
      chk_idle_outputs("midrst");
      resetn = 1;
      axi_write(32'h84, 32'h600DCAFE, 4'hF, 2, 0);
      axi_read(32'h80, 0);
      axi_read(32'h84, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
